// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if
//   Bundles the two buses of the fetch unit:
//   - instruction memory read port: Mem_Req/Mem_Addr out, Mem_Ack/Mem_Rdata in
//   - downstream instruction handshake: Op_Code/Operand/Instr_Valid out,
//     Instr_Ready/Branch_Taken/Branch_Target in
//   modport master : the fetch unit side
//   modport slave  : the memory + decoder side (testbench or system)
interface instruction_fetch_if #(
    parameter int ADDR_W = 12
);
    logic              Mem_Req;
    logic [ADDR_W-1:0] Mem_Addr;
    logic              Mem_Ack;
    logic [15:0]       Mem_Rdata;
    logic [3:0]        Op_Code;
    logic [ADDR_W-1:0] Operand;
    logic              Instr_Valid;
    logic              Instr_Ready;
    logic              Branch_Taken;
    logic [ADDR_W-1:0] Branch_Target;

    modport master (
        output Mem_Req, Mem_Addr, Op_Code, Operand, Instr_Valid,
        input  Mem_Ack, Mem_Rdata, Instr_Ready, Branch_Taken, Branch_Target
    );

    modport slave (
        input  Mem_Req, Mem_Addr, Op_Code, Operand, Instr_Valid,
        output Mem_Ack, Mem_Rdata, Instr_Ready, Branch_Taken, Branch_Target
    );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Fetches 16-bit instruction words from instruction memory, splits them into
//   opcode [15:12] and operand [11:0], and hands them downstream with a
//   valid/ready handshake. Supports branch redirect on acceptance, a HALT
//   opcode (4'hF) with Resume, and a memory-ack timeout that latches a sticky
//   error and parks the unit in HALT.
// Ports
//   Clk        : clock, all state changes on the rising edge
//   Rst_n      : synchronous active-low reset
//   bus        : instruction_fetch_if.master (memory read port + instruction
//                handshake)
//   Resume     : pulse, leaves HALT (ignored once Fetch_Err is set)
//   Halted     : unit is in HALT
//   Fetch_Err  : sticky memory-timeout flag, cleared only by reset
// All outputs come straight from flops.
module instruction_fetch #(
    parameter int              ADDR_W     = 12,
    parameter logic [ADDR_W-1:0] START_ADDR = 12'h000,
    parameter int              TIMEOUT    = 15
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    instruction_fetch_if.master  bus,
    input  logic                 Resume,
    output logic                 Halted,
    output logic                 Fetch_Err
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [3:0]          op_code_q, op_code_d;
    logic [ADDR_W-1:0]   operand_q, operand_d;
    logic                mem_req_q, mem_req_d;
    logic                instr_valid_q, instr_valid_d;
    logic                halted_q, halted_d;
    logic                fetch_err_q, fetch_err_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [WAIT_W-1:0]   wait_inc;

    assign wait_inc = wait_q + WAIT_W'(1);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        op_code_d   = op_code_q;
        operand_d   = operand_q;
        fetch_err_d = fetch_err_q;
        wait_d      = wait_q;

        case (state_q)
            IDLE: begin
                // Any Mem_Ack seen here is stale and is simply not looked at.
                state_d = FETCH;
                wait_d  = '0;
            end
            FETCH: begin
                // Ack wins over timeout when both happen in the same cycle.
                if (bus.Mem_Ack) begin
                    op_code_d = bus.Mem_Rdata[15:12];
                    operand_d = ADDR_W'(bus.Mem_Rdata[11:0]);
                    state_d   = HOLD;
                end else if (wait_inc == WAIT_W'(TIMEOUT)) begin
                    wait_d      = wait_inc;
                    fetch_err_d = 1'b1;
                    state_d     = HALT;
                end else begin
                    wait_d = wait_inc;
                end
            end
            HOLD: begin
                if (bus.Instr_Ready) begin
                    if (op_code_q == 4'hF) begin
                        // HALT opcode: PC stays on the halt instruction.
                        state_d = HALT;
                    end else begin
                        pc_d    = bus.Branch_Taken ? bus.Branch_Target
                                                   : pc_q + ADDR_W'(1);
                        state_d = FETCH;
                        wait_d  = '0;
                    end
                end
            end
            HALT: begin
                if (Resume && !fetch_err_q) begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = FETCH;
                    wait_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered yet
        // line up with the state they describe.
        mem_req_d     = (state_d == FETCH);
        instr_valid_d = (state_d == HOLD);
        halted_d      = (state_d == HALT);
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q       <= IDLE;
            pc_q          <= START_ADDR;
            op_code_q     <= '0;
            operand_q     <= '0;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fetch_err_q   <= 1'b0;
            wait_q        <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            op_code_q     <= op_code_d;
            operand_q     <= operand_d;
            mem_req_q     <= mem_req_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            fetch_err_q   <= fetch_err_d;
            wait_q        <= wait_d;
        end
    end

    assign bus.Mem_Req     = mem_req_q;
    assign bus.Mem_Addr    = pc_q;
    assign bus.Op_Code     = op_code_q;
    assign bus.Operand     = operand_q;
    assign bus.Instr_Valid = instr_valid_q;
    assign Halted          = halted_q;
    assign Fetch_Err       = fetch_err_q;
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter ADDR_W, default 12, width of program address and operand field.
REQ-002 Parameter START_ADDR, default 12'h000, first fetch address after reset.
REQ-003 Parameter TIMEOUT, default 15, maximum cycles Mem_Req waits for Mem_Ack.
REQ-004 Clk  in  1  single clock; all state changes on rising edge.
REQ-005 Rst_n  in  1  synchronous, active-low reset.
REQ-006 Mem_Req  out  1  instruction memory read request.
REQ-007 Mem_Addr  out  ADDR_W  read address, equal to the PC.
REQ-008 Mem_Ack  in  1  read data valid this cycle.
REQ-009 Mem_Rdata  in  16  instruction word: [15:12] opcode, [11:0] operand.
REQ-010 Op_Code  out  4  latched opcode; drives the control decoder's opcode input.
REQ-011 Operand  out  ADDR_W  latched operand field.
REQ-012 Instr_Valid  out  1  Op_Code/Operand hold a valid instruction.
REQ-013 Instr_Ready  in  1  downstream accepts the instruction this cycle.
REQ-014 Branch_Taken  in  1  redirect request, sampled only on the accept cycle.
REQ-015 Branch_Target  in  ADDR_W  redirect address.
REQ-016 Resume  in  1  pulse that leaves HALT.
REQ-017 Halted  out  1  block is in HALT.
REQ-018 Fetch_Err  out  1  sticky flag, memory timeout occurred.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, HOLD and HALT, with reset state IDLE.
REQ-020 IDLE SHALL go to FETCH unconditionally on the next edge.
REQ-021 In FETCH, Mem_Req SHALL be 1 and Mem_Addr SHALL equal the PC, held stable until Mem_Ack.
REQ-022 Mem_Ack=1 in FETCH SHALL capture Mem_Rdata[15:12] into Op_Code and Mem_Rdata[11:0] into Operand, and SHALL move the FSM to HOLD; Instr_Valid SHALL be 1 on the following cycle (1-cycle latency from the ack edge).
REQ-023 Mem_Ack SHALL be ignored outside FETCH.
REQ-024 In HOLD, Instr_Valid SHALL be 1 and Op_Code/Operand SHALL be stable until Instr_Valid&Instr_Ready.
REQ-025 On acceptance, if the accepted Op_Code is 4'b1111, the FSM SHALL go to HALT with the PC unchanged, and Branch_Taken SHALL be ignored.
REQ-026 On any other acceptance, the PC SHALL take Branch_Target if Branch_Taken=1, else PC+1 modulo 2^ADDR_W (all-ones wraps to 0), and the FSM SHALL go to FETCH.
REQ-027 Branch_Taken SHALL be ignored in every cycle without acceptance.
REQ-028 In HALT, Halted SHALL be 1, Mem_Req SHALL be 0 and Instr_Valid SHALL be 0.
REQ-029 Resume=1 in HALT SHALL set PC to PC+1 (wrapping) and return to FETCH, except when Fetch_Err=1, in which case Resume SHALL be ignored.
REQ-030 A wait counter SHALL clear on entry to FETCH and increment each FETCH cycle without Mem_Ack.
REQ-031 When the wait counter reaches TIMEOUT without Mem_Ack, Fetch_Err SHALL set, and the FSM SHALL go to HALT on the next edge.
REQ-032 Mem_Ack in the same cycle the count reaches TIMEOUT SHALL take priority as a normal capture, with no error.
REQ-033 Fetch_Err SHALL clear only on reset.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 Rst_n=0 at a rising edge SHALL, from any state including mid-FETCH or HOLD, force the following on that edge: state IDLE, PC=START_ADDR, Mem_Req=0, Mem_Addr=START_ADDR, Op_Code=0, Operand=0, Instr_Valid=0, Halted=0, Fetch_Err=0, wait counter=0.
REQ-036 A Mem_Ack arriving during reset or in IDLE SHALL be discarded.

Verification
REQ-037 Sequential fetch: memory holds 16'h2005 at 0 and 16'h5003 at 1, with Mem_Ack 1 cycle after Mem_Req and Instr_Ready=1 -> Op_Code 2/Operand 5, then Op_Code 5/Operand 3, with Mem_Addr 0 then 1.
REQ-038 Backpressure: Instr_Ready=0 for 4 cycles in HOLD -> Instr_Valid stays 1, Op_Code/Operand are unchanged, and no Mem_Req is issued.
REQ-039 Branch: accept at PC=3 with Branch_Taken=1 and Branch_Target=12'h0A0 -> next Mem_Addr=12'h0A0; Branch_Taken=1 without acceptance -> no effect.
REQ-040 Halt/resume: 16'hF000 at PC=7 accepted -> Halted=1 and Mem_Req=0; Resume pulse -> Mem_Addr=8. Wrap case: accept at PC=12'hFFF without branch -> Mem_Addr=12'h000.
REQ-041 Timeout: Mem_Ack withheld for 15 FETCH cycles -> Fetch_Err=1 and Halted=1, and Resume is ignored. Separately, Mem_Ack on the 15th cycle -> normal capture with Fetch_Err=0.
REQ-042 Reset mid-HOLD with Instr_Valid=1 -> on the next edge Instr_Valid=0 and PC=START_ADDR; then Mem_Req=1 with Mem_Addr=0 two cycles after Rst_n rises.
